// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// Holds the digit limits, the run/stop state type and the BCD increment helper.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] ONES_MAX     = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ONE      = 4'd1;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  // One-second advance; 59:59 rolls over to 00:00.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != ONES_MAX) begin
      r.sec_ones = t.sec_ones + BCD_ONE;
    end else begin
      r.sec_ones = '0;
      if (t.sec_tens != SEC_TENS_MAX) begin
        r.sec_tens = t.sec_tens + BCD_ONE;
      end else begin
        r.sec_tens = '0;
        if (t.min_ones != ONES_MAX) begin
          r.min_ones = t.min_ones + BCD_ONE;
        end else begin
          r.min_ones = '0;
          if (t.min_tens != MIN_TENS_MAX) begin
            r.min_tens = t.min_tens + BCD_ONE;
          end else begin
            r.min_tens = '0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-FF synchroniser -> stability filter; press is a one-cycle pulse
// in the cycle the debounced level rises (2 sync + DEBOUNCE cycles after the raw edge).
module button_debounce #(
  parameter int unsigned DEBOUNCE = 240_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    // Any sample agreeing with the current level restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch: debounced start/clear buttons, 1 Hz prescaler, packed-BCD output.
// Outputs are registered; new data and tick appear the cycle after a terminal count.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 12_000_000,
  parameter int unsigned DEBOUNCE = 240_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [15:0] data,
  output logic        running,
  output logic        tick
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);

  logic start_level, start_press;
  logic clear_level, clear_press;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_start_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_start),
    .level   (start_level),
    .press   (start_press)
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_clear_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .level   (clear_level),
    .press   (clear_press)
  );

  // Only the press pulses drive events; the debounced levels are left unused.
  logic unused_levels;
  assign unused_levels = start_level ^ clear_level;

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  bcd_time_t        data_q, data_d;
  logic             tick_q, tick_d;
  logic             terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_press) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
  end

  // Advance uses the pre-toggle state, so a stop on a terminal cycle still advances.
  always_comb begin
    terminal = (state_q == ST_RUN) && (presc_q == PRE_W'(CLK_DIV - 1));
    presc_d  = presc_q;
    data_d   = data_q;
    tick_d   = 1'b0;
    if (state_q == ST_RUN) begin
      presc_d = terminal ? '0 : presc_q + PRE_W'(1);
    end
    if (terminal) begin
      data_d = bcd_inc(data_q);
      tick_d = 1'b1;
    end
    if (clear_press) begin
      presc_d = '0;
      data_d  = '0;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      presc_q   <= '0;
      data_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      presc_q   <= presc_d;
      data_q    <= data_d;
      tick_q    <= tick_d;
    end
  end

  assign data    = data_q;
  assign running = running_q;
  assign tick    = tick_q;

endmodule
